// File: rtl/truth_table_checker.sv
// Exhaustive truth-table checker: sweeps every stim value, lets the DUT and the
// reference settle, compares their outputs, and records a summary of the mismatches.
module truth_table_checker #(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] dut_out,
  input  logic [OUT_W-1:0] ref_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [IN_W-1:0]  first_fail_vec,
  output logic             first_fail_valid
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_FINISH} state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [IN_W-1:0]  stim_q, stim_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [IN_W-1:0]  ffv_q, ffv_d;
  logic             ffvalid_q, ffvalid_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d   = state_q;
    stim_d    = stim_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    pass_d    = pass_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d   = S_WAIT;
          stim_d    = '0;
          cnt_d     = '0;
          err_cnt_d = '0;
          ffv_d     = '0;
          ffvalid_d = 1'b0;
          pass_d    = 1'b0;
        end
      end
      S_WAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_CHECK: begin
        if (dut_out != ref_out) begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          if (!ffvalid_q) begin
            ffv_d     = stim_q;
            ffvalid_d = 1'b1;
          end
        end
        // pass is taken from the updated count so a mismatch on the last vector counts.
        if (stim_q == '1) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d = S_WAIT;
          stim_d  = stim_q + 1'b1;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        stim_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition but leaves the error record intact.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      stim_d  = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      stim_q    <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stim_q    <= stim_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_cnt          = err_cnt_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: three parameterisations, expected stim
// sequence held in a scoreboard queue and popped as the checker steps through it.
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: defaults, reference XOR, DUT either XOR or AND.
  logic       start0 = 1'b0, abort0 = 1'b0, and_mode = 1'b0;
  logic [1:0] stim0, ffv0;
  logic       dut0, ref0, busy0, done0, pass0, ffvalid0;
  logic [7:0] err0;
  assign ref0 = stim0[1] ^ stim0[0];
  assign dut0 = and_mode ? (stim0[1] & stim0[0]) : (stim0[1] ^ stim0[0]);

  // Instance 1: one-bit error counter, DUT always inverted.
  logic       start1 = 1'b0;
  logic [1:0] stim1, ffv1;
  logic       dut1, ref1, busy1, done1, pass1, ffvalid1;
  logic [0:0] err1;
  assign ref1 = ^stim1;
  assign dut1 = ~(^stim1);

  // Instance 2: three inputs, three settle cycles, DUT matches.
  logic       start2 = 1'b0;
  logic [2:0] stim2, ffv2;
  logic       dut2, ref2, busy2, done2, pass2, ffvalid2;
  logic [7:0] err2;
  assign ref2 = ^stim2;
  assign dut2 = stim2[0] ^ stim2[1] ^ stim2[2];

  truth_table_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .stim(stim0),
    .dut_out(dut0), .ref_out(ref0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .first_fail_vec(ffv0), .first_fail_valid(ffvalid0));

  truth_table_checker #(.ERR_W(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .stim(stim1),
    .dut_out(dut1), .ref_out(ref1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_fail_vec(ffv1), .first_fail_valid(ffvalid1));

  truth_table_checker #(.IN_W(3), .SETTLE(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .stim(stim2),
    .dut_out(dut2), .ref_out(ref2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .first_fail_vec(ffv2), .first_fail_valid(ffvalid2));

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_stim(input int id);
    case (id)
      0:       return 32'(stim0);
      1:       return 32'(stim1);
      default: return 32'(stim2);
    endcase
  endfunction

  function automatic logic [31:0] obs_busy(input int id);
    case (id)
      0:       return 32'(busy0);
      1:       return 32'(busy1);
      default: return 32'(busy2);
    endcase
  endfunction

  function automatic logic [31:0] obs_done(input int id);
    case (id)
      0:       return 32'(done0);
      1:       return 32'(done1);
      default: return 32'(done2);
    endcase
  endfunction

  function automatic logic [31:0] obs_pass(input int id);
    case (id)
      0:       return 32'(pass0);
      1:       return 32'(pass1);
      default: return 32'(pass2);
    endcase
  endfunction

  function automatic logic [31:0] obs_err(input int id);
    case (id)
      0:       return 32'(err0);
      1:       return 32'(err1);
      default: return 32'(err2);
    endcase
  endfunction

  function automatic logic [31:0] obs_ffv(input int id);
    case (id)
      0:       return 32'(ffv0);
      1:       return 32'(ffv1);
      default: return 32'(ffv2);
    endcase
  endfunction

  function automatic logic [31:0] obs_ffvalid(input int id);
    case (id)
      0:       return 32'(ffvalid0);
      1:       return 32'(ffvalid1);
      default: return 32'(ffvalid2);
    endcase
  endfunction

  task automatic set_start(input int id, input logic v);
    case (id)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  // Waits (bounded) until an instance shows a given stim value, sampled after edges.
  task automatic wait_stim(input int id, input int val, input int max_cycles);
    int k = 0;
    while (obs_stim(id) !== 32'(val) && k < max_cycles) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_stim", obs_stim(id), 32'(val));
  endtask

  // One full run. Called from a point away from the rising edge; start is sampled on
  // the next edge. done is expected on the 2^IN_W*(SETTLE+1)-th edge after that edge,
  // i.e. in the following cycle. restart_at >= 0 pulses start mid-run (must be ignored).
  task automatic run(input int id, input int in_w, input int settle, input int exp_err,
                     input int exp_ffv, input int exp_ffvalid, input int exp_pass,
                     input int restart_at);
    int n = 1 << in_w;
    int k = 0;
    int hold = 1;
    int exp_v;
    logic [31:0] prev;
    bit seen_done = 1'b0;
    for (int v = 0; v < n; v++) exp_q.push_back(v);
    set_start(id, 1'b1);
    @(posedge clk); #1;
    set_start(id, 1'b0);
    check("busy_on", obs_busy(id), 32'd1);
    check("stim_first", obs_stim(id), 32'(exp_q.pop_front()));
    prev = obs_stim(id);
    while (!seen_done && k < n * (settle + 1) + 8) begin
      @(posedge clk); #1;
      k++;
      set_start(id, (k == restart_at) ? 1'b1 : 1'b0);
      if (obs_done(id) === 32'd1) begin
        seen_done = 1'b1;
      end else if (obs_stim(id) !== prev) begin
        check("stim_hold", 32'(hold), 32'(settle + 1));
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check("stim_seq", obs_stim(id), 32'(exp_v));
        prev = obs_stim(id);
        hold = 1;
      end else begin
        hold++;
      end
    end
    set_start(id, 1'b0);
    check("done_seen", 32'(seen_done), 32'd1);
    check("done_cycle", 32'(k), 32'(n * (settle + 1)));
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check("finish_stim", obs_stim(id), 32'(n - 1));
    check("pass", obs_pass(id), 32'(exp_pass));
    check("err_cnt", obs_err(id), 32'(exp_err));
    check("ff_vec", obs_ffv(id), 32'(exp_ffv));
    check("ff_valid", obs_ffvalid(id), 32'(exp_ffvalid));
    @(posedge clk); #1;
    check("done_pulse_end", obs_done(id), 32'd0);
    check("idle_busy", obs_busy(id), 32'd0);
    check("idle_stim", obs_stim(id), 32'd0);
    check("idle_pass_hold", obs_pass(id), 32'(exp_pass));
    check("idle_err_hold", obs_err(id), 32'(exp_err));
  endtask

  initial begin
    int dones;

    // Power-on reset.
    repeat (2) @(negedge clk);
    check("rst_stim", obs_stim(0), 32'd0);
    check("rst_busy", obs_busy(0), 32'd0);
    check("rst_err", obs_err(0), 32'd0);
    check("rst_busy2", obs_busy(2), 32'd0);
    rst_n = 1'b1;

    // Matching XOR, started right after reset release.
    run(0, 2, 1, 0, 0, 0, 1, -1);

    // AND vs XOR: mismatches at 1, 2, 3; a start pulse mid-run is ignored.
    and_mode = 1'b1;
    run(0, 2, 1, 3, 1, 1, 0, 3);

    // Abort while stim=2: error record kept, no done, pass cleared.
    set_start(0, 1'b1);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    wait_stim(0, 2, 10);
    abort0 = 1'b1;
    @(posedge clk); #1;
    abort0 = 1'b0;
    check("abort_busy", obs_busy(0), 32'd0);
    check("abort_stim", obs_stim(0), 32'd0);
    check("abort_done", obs_done(0), 32'd0);
    check("abort_pass", obs_pass(0), 32'd0);
    check("abort_err", obs_err(0), 32'd1);
    check("abort_ffv", obs_ffv(0), 32'd1);
    check("abort_ffvalid", obs_ffvalid(0), 32'd1);
    dones = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done0 === 1'b1) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);

    // start together with abort in IDLE: nothing happens.
    start0 = 1'b1;
    abort0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    abort0 = 1'b0;
    check("start_abort_busy", obs_busy(0), 32'd0);
    check("start_abort_err", obs_err(0), 32'd1);

    // Clean full run after the abort.
    and_mode = 1'b0;
    run(0, 2, 1, 0, 0, 0, 1, -1);

    // Reset pulse mid-run: outputs clear before any clock edge.
    and_mode = 1'b1;
    set_start(0, 1'b1);
    @(posedge clk); #1;
    set_start(0, 1'b0);
    wait_stim(0, 2, 10);
    check("pre_rst_err", obs_err(0), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_stim", obs_stim(0), 32'd0);
    check("arst_busy", obs_busy(0), 32'd0);
    check("arst_done", obs_done(0), 32'd0);
    check("arst_pass", obs_pass(0), 32'd0);
    check("arst_err", obs_err(0), 32'd0);
    check("arst_ffv", obs_ffv(0), 32'd0);
    check("arst_ffvalid", obs_ffvalid(0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    and_mode = 1'b0;
    run(0, 2, 1, 0, 0, 0, 1, -1);

    // One-bit counter saturates at 1 despite four mismatches.
    run(1, 2, 1, 1, 0, 1, 0, -1);

    // Three inputs, four cycles per vector.
    run(2, 3, 3, 0, 0, 0, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
